// File: rtl/char_feed_if.sv
// Handshake bundle between an ASCII byte producer, the char feed FIFO and the case-conversion stage.
// lower_cnt is carried only when LOWER_CNT_EN is defined.
interface char_feed_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       flush;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic       out_lower;
`ifdef LOWER_CNT_EN
  logic [7:0] lower_cnt;
`endif

  modport master (
    output in_valid, in_data, flush, out_ready,
    input  in_ready, out_valid, out_data, out_lower
`ifdef LOWER_CNT_EN
    , input lower_cnt
`endif
  );

  modport slave (
    input  in_valid, in_data, flush, out_ready,
    output in_ready, out_valid, out_data, out_lower
`ifdef LOWER_CNT_EN
    , output lower_cnt
`endif
  );
endinterface

// File: rtl/char_feed_fifo.sv
// Show-ahead byte FIFO feeding the case-conversion stage, flagging lowercase ASCII at the head.
// Optional feature macro LOWER_CNT_EN adds a saturating count of popped lowercase bytes.
module char_feed_fifo #(
  parameter int DEPTH = 4
) (
  input logic        clk,
  input logic        rst,
  char_feed_if.slave bus
);
  localparam int             AW   = $clog2(DEPTH);
  localparam logic [AW:0]    FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0]  LAST = AW'(DEPTH - 1);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          in_ready;
  logic          out_valid;
  logic          push;
  logic          pop;
  logic [7:0]    head;
  logic          head_lower;

  // Handshake flags come from registered count only, so out_ready never reaches in_ready.
  assign in_ready   = (count != FULL);
  assign out_valid  = (count != '0);
  assign head       = mem[rd_ptr];
  assign head_lower = out_valid && (head >= 8'h61) && (head <= 8'h7a);
  assign push       = bus.in_valid && in_ready;
  assign pop        = out_valid && bus.out_ready;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = head;
  assign bus.out_lower = head_lower;

  // Storage is deliberately not reset; out_valid hides stale entries.
  always_ff @(posedge clk) begin
    if (push && !bus.flush) begin
      mem[wr_ptr] <= bus.in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef LOWER_CNT_EN
  logic [7:0] lower_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lower_cnt <= '0;
    end else if (bus.flush) begin
      lower_cnt <= '0;
    end else if (pop && head_lower && (lower_cnt != 8'hff)) begin
      lower_cnt <= lower_cnt + 8'd1;
    end
  end

  assign bus.lower_cnt = lower_cnt;
`endif
endmodule
